// File: rtl/run_monitor.sv
// Run-control and result-dump block: starts the core, counts RUN cycles and retired
// instructions, stops on the halt instruction or a watchdog, then streams a memory window.
module run_monitor #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           CNT_WIDTH  = 32,
  parameter logic [31:0]           HALT_INSTR = 32'h44000300,
  parameter int unsigned           TIMEOUT    = 100000,
  parameter logic [ADDR_WIDTH-1:0] DUMP_BASE  = ADDR_WIDTH'(32'h2000),
  parameter int unsigned           DUMP_LEN   = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_en,
  input  logic [31:0]           instruction,
  input  logic                  instr_valid,
  output logic                  halt,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [CNT_WIDTH-1:0]  dump_index,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [1:0]            stop_cause,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_INDEX   = CNT_WIDTH'(DUMP_LEN - 1);
  localparam bit                   DUMP_EMPTY   = (DUMP_LEN == 0);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STOP, S_READ, S_CAPTURE, S_SEND, S_DONE
  } state_t;

  state_t                 state;
  logic                   halt_seen;
  logic [CNT_WIDTH-1:0]   cycle_inc;
  logic [CNT_WIDTH-1:0]   instr_inc;

  // Counters stick at all-ones instead of wrapping.
  assign cycle_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_WIDTH'(1);
  assign instr_inc = (instr_count == '1) ? instr_count : instr_count + CNT_WIDTH'(1);
  assign halt_seen = instr_valid && (instruction == HALT_INSTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      halt        <= 1'b1;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_index  <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      stop_cause  <= 2'd0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          halt <= 1'b1;
          if (run_en) begin
            state <= S_RUN;
            halt  <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_count <= cycle_inc;
          if (instr_valid) instr_count <= instr_inc;
          // Halt instruction wins over a watchdog expiring in the same cycle.
          if (halt_seen) begin
            stop_cause <= 2'd1;
            halt       <= 1'b1;
            state      <= S_STOP;
          end else if (cycle_count == TIMEOUT_LAST) begin
            stop_cause <= 2'd2;
            halt       <= 1'b1;
            state      <= S_STOP;
          end
        end
        S_STOP: begin
          if (DUMP_EMPTY) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            mem_addr   <= DUMP_BASE;
            dump_index <= '0;
            mem_rd     <= 1'b1;
            state      <= S_READ;
          end
        end
        S_READ: begin
          mem_rd <= 1'b0;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          dump_data  <= mem_rdata;
          dump_valid <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_index == LAST_INDEX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              dump_index <= dump_index + CNT_WIDTH'(1);
              mem_addr   <= mem_addr + ADDR_WIDTH'(1);
              mem_rd     <= 1'b1;
              state      <= S_READ;
            end
          end
        end
        S_DONE: begin
          done <= 1'b1;
          halt <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: halt stop, watchdog stop, dump ordering, back-pressure,
// reset mid-dump and an empty dump window, checked against a scoreboard of expected words.
module tb_run_monitor;

  localparam logic [31:0] HALT = 32'h44000300;
  localparam int unsigned LEN  = 8;

  typedef struct packed {
    logic [31:0] idx;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, run_en, instr_valid, dump_ready;
  logic [31:0] instruction;
  logic [7:0]  mem_rdata;
  logic        halt, mem_rd, dump_valid, done;
  logic [31:0] mem_addr, dump_index, cycle_count, instr_count;
  logic [7:0]  dump_data;
  logic [1:0]  stop_cause;
  logic        b_halt, b_mem_rd, b_dump_valid, b_done;
  logic [31:0] b_mem_addr, b_dump_index, b_cycle_count, b_instr_count;
  logic [7:0]  b_dump_data;
  logic [1:0]  b_stop_cause;

  logic [7:0]  mem [0:255];
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          b_rd_count = 0;
  bit          expect_done = 1'b0;

  always #5 clk = ~clk;

  run_monitor #(.TIMEOUT(50), .DUMP_BASE(32'h2000), .DUMP_LEN(LEN)) u_dut (
    .clk(clk), .reset(reset), .run_en(run_en), .instruction(instruction),
    .instr_valid(instr_valid), .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_index(dump_index), .cycle_count(cycle_count),
    .instr_count(instr_count), .stop_cause(stop_cause), .done(done));

  run_monitor #(.TIMEOUT(50), .DUMP_BASE(32'h2000), .DUMP_LEN(0)) u_empty (
    .clk(clk), .reset(reset), .run_en(run_en), .instruction(instruction),
    .instr_valid(instr_valid), .halt(b_halt), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
    .mem_rdata(mem_rdata), .dump_valid(b_dump_valid), .dump_ready(dump_ready),
    .dump_data(b_dump_data), .dump_index(b_dump_index), .cycle_count(b_cycle_count),
    .instr_count(b_instr_count), .stop_cause(b_stop_cause), .done(b_done));

  // Synchronous memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_push(input int mode);
    for (int i = 0; i < int'(LEN); i++) begin
      if (mode == 0)      mem[i] = 8'(8'h11 * (i + 1));
      else if (mode == 1) mem[i] = 8'(8'hA0 + i);
      else                mem[i] = 8'($urandom);
      sb.push_back('{idx: 32'(i), data: mem[i]});
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks read addresses.
  always @(negedge clk) begin
    if (b_mem_rd) b_rd_count++;
    if (expect_done) begin
      chk("done_after_last", 64'(done), 64'd1);
      expect_done = 1'b0;
    end
    if (mem_rd) begin
      chk("rd_while_valid", 64'(dump_valid), 64'd0);
      if (sb.size() > 0) chk("mem_addr", 64'(mem_addr), 64'(32'h2000 + sb[0].idx));
    end
    if (dump_valid && dump_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("dump_index", 64'(dump_index), 64'(e.idx));
        chk("dump_data", 64'(dump_data), 64'(e.data));
        if (dump_index == LEN - 1) expect_done = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit          found;
    logic [7:0]  held_data;
    logic [31:0] held_idx;
    int          exp_instr;

    reset = 1'b1; run_en = 1'b0; instr_valid = 1'b0; dump_ready = 1'b1;
    instruction = 32'h13;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_halt", 64'(halt), 64'd1);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cause", 64'(stop_cause), 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    step();
    chk("idle_halt", 64'(halt), 64'd1);

    // Run 1: ten instructions then the halt instruction on RUN cycle 11.
    load_and_push(0);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    chk("run_halt_low", 64'(halt), 64'd0);
    chk("run_cycles0", 64'(cycle_count), 64'd0);
    for (int i = 1; i <= 10; i++) begin
      instr_valid = 1'b1;
      instruction = 32'h13 + 32'(i);
      step();
    end
    instruction = HALT;
    step();
    instr_valid = 1'b0;
    instruction = 32'h13;
    chk("h_cause", 64'(stop_cause), 64'd1);
    chk("h_instr", 64'(instr_count), 64'd11);
    chk("h_cycles", 64'(cycle_count), 64'd11);
    chk("h_halt", 64'(halt), 64'd1);
    chk("e_done_stop", 64'(b_done), 64'd0);
    step();
    chk("read_strobe", 64'(mem_rd), 64'd1);
    chk("e_done", 64'(b_done), 64'd1);
    chk("cycles_frozen", 64'(cycle_count), 64'd11);
    step();
    chk("capture_rd", 64'(mem_rd), 64'd0);
    chk("capture_valid", 64'(dump_valid), 64'd0);
    step();
    chk("first_valid", 64'(dump_valid), 64'd1);

    // Back-pressure on word 2 for seven cycles.
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (dump_valid && dump_index == 2) begin found = 1'b1; break; end
      step();
    end
    dump_ready = 1'b0;
    chk("reach_word2", 64'(found), 64'd1);
    held_data = dump_data;
    held_idx  = dump_index;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("stall_valid", 64'(dump_valid), 64'd1);
      chk("stall_data", 64'(dump_data), 64'(held_data));
      chk("stall_index", 64'(dump_index), 64'(held_idx));
      chk("stall_rd", 64'(mem_rd), 64'd0);
    end
    dump_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin found = 1'b1; break; end
      step();
    end
    chk("run1_done", 64'(found), 64'd1);
    chk("run1_sb_empty", 64'(sb.size()), 64'd0);
    chk("run1_cause_kept", 64'(stop_cause), 64'd1);
    chk("run1_instr_kept", 64'(instr_count), 64'd11);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    chk("done_sticky", 64'(done), 64'd1);
    chk("done_halt", 64'(halt), 64'd1);

    // Run 2: watchdog with an unretired halt word; reset during word 5.
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_and_push(1);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    exp_instr = 0;
    for (int i = 1; i <= 50; i++) begin
      instr_valid = (i % 3 == 0);
      instruction = (i == 20) ? HALT : 32'h13;
      if (instr_valid) exp_instr++;
      step();
      if (i == 49) chk("to_still_running", 64'(halt), 64'd0);
    end
    instr_valid = 1'b0;
    instruction = 32'h13;
    chk("to_cause", 64'(stop_cause), 64'd2);
    chk("to_cycles", 64'(cycle_count), 64'd50);
    chk("to_instr", 64'(instr_count), 64'(exp_instr));
    chk("to_e_cause", 64'(b_stop_cause), 64'd2);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (dump_valid && dump_index == 5) begin found = 1'b1; break; end
      step();
    end
    reset = 1'b1;
    chk("reach_word5", 64'(found), 64'd1);
    #1;
    chk("mid_rst_valid", 64'(dump_valid), 64'd0);
    chk("mid_rst_halt", 64'(halt), 64'd1);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_cause", 64'(stop_cause), 64'd0);
    chk("mid_rst_index", 64'(dump_index), 64'd0);
    sb.delete();
    step();
    reset = 1'b0;

    // Run 3: halt instruction lands on the watchdog cycle.
    load_and_push(2);
    run_en = 1'b1;
    step();
    run_en = 1'b0;
    chk("r3_cycles0", 64'(cycle_count), 64'd0);
    chk("r3_instr0", 64'(instr_count), 64'd0);
    for (int i = 1; i <= 50; i++) begin
      instr_valid = (i == 50);
      instruction = (i == 50) ? HALT : 32'h13;
      step();
    end
    instr_valid = 1'b0;
    instruction = 32'h13;
    chk("r3_cause", 64'(stop_cause), 64'd1);
    chk("r3_cycles", 64'(cycle_count), 64'd50);
    chk("r3_instr", 64'(instr_count), 64'd1);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin found = 1'b1; break; end
      step();
    end
    chk("r3_done", 64'(found), 64'd1);
    step();
    chk("r3_sb_empty", 64'(sb.size()), 64'd0);
    chk("e_no_reads", 64'(b_rd_count), 64'd0);
    chk("e_done_final", 64'(b_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
